// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and constants for the pipeline controller
package pipe_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic TRUE = 1'b1;
    localparam logic FALSE = 1'b0;
    typedef enum logic [1:0] {
        PURGE    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the 5-stage core with purge sequencing and perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_hazard_stall,
    input  logic             branch_taken_ex,
    input  logic [XLEN-1:0]  branch_target_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_wb,
    output logic             pc_redirect_en,
    output logic [XLEN-1:0]  pc_redirect_addr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_e state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic err_q, err_d;

    assign pc_redirect_addr = branch_target_ex;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_timeout_err = err_q;

    // next state and per-stage controls; memory wait outranks branch, branch outranks load-use
    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        wait_d = wait_q;
        stall_if = FALSE;
        stall_id = FALSE;
        stall_ex = FALSE;
        stall_mem = FALSE;
        flush_id = FALSE;
        flush_ex = FALSE;
        flush_wb = FALSE;
        pc_redirect_en = FALSE;
        case (state_q)
            PURGE: begin
                {stall_if, stall_id, stall_ex, stall_mem} = {4{TRUE}};
                {flush_id, flush_ex, flush_wb} = {3{TRUE}};
                hold_d = (hold_q == '0) ? hold_q : hold_q - HW'(1);
                state_d = (hold_q == '0) ? RUN : PURGE;
            end
            RUN: begin
                if (dmem_req_mem && !dmem_ack) begin
                    {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = {5{TRUE}};
                    wait_d = '0;
                    state_d = MEM_WAIT;
                end else if (branch_taken_ex) begin
                    {pc_redirect_en, flush_id, flush_ex} = {3{TRUE}};
                end else if (load_hazard_stall) begin
                    {stall_if, stall_id, flush_ex} = {3{TRUE}};
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d = RUN;
                end else begin
                    {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = {5{TRUE}};
                    wait_d = (wait_q == WW'(MEM_TIMEOUT)) ? wait_q : wait_q + WW'(1);
                end
            end
            default: state_d = PURGE;
        endcase
    end

    // counters and the sticky timeout flag; the pipeline keeps waiting after a timeout
    always_comb begin
        stall_cnt_d = stall_cnt_q + ((stall_if && state_q != PURGE) ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + (pc_redirect_en ? CNT_W'(1) : CNT_W'(0));
        err_d = err_q || (state_q == MEM_WAIT && wait_d == WW'(MEM_TIMEOUT));
    end

    // state registers; reset abandons any outstanding access and restarts the purge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PURGE;
            hold_q <= HW'(RST_HOLD_CYCLES - 1);
            wait_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q <= FALSE;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            wait_q <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        string tag;
        logic [7:0] ctrl;
        logic [XLEN-1:0] addr;
        logic [31:0] sc;
        logic [31:0] fc;
        logic err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lh = 1'b0, bt = 1'b0, req = 1'b0, ack = 1'b0;
    logic [XLEN-1:0] tgt = '0;
    logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, pc_redirect_en;
    logic [XLEN-1:0] pc_redirect_addr;
    logic [31:0] stall_cnt, flush_cnt;
    logic mem_timeout_err;
    logic [7:0] ctrl;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.RST_HOLD_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_hazard_stall(lh), .branch_taken_ex(bt), .branch_target_ex(tgt),
        .dmem_req_mem(req), .dmem_ack(ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_wb(flush_wb),
        .pc_redirect_en(pc_redirect_en), .pc_redirect_addr(pc_redirect_addr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout_err(mem_timeout_err)
    );

    assign ctrl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, pc_redirect_en};

    task automatic push(input string tag, input logic [7:0] c, input logic [31:0] sc, input logic [31:0] fc, input logic err);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.addr = tgt; e.sc = sc; e.fc = fc; e.err = err;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        assert (ctrl === e.ctrl) else begin errors++; $error("FAIL %s ctrl: got %b required %b", e.tag, ctrl, e.ctrl); end
        checks++;
        assert (pc_redirect_addr === e.addr) else begin errors++; $error("FAIL %s addr: got %h required %h", e.tag, pc_redirect_addr, e.addr); end
        checks++;
        assert (stall_cnt === e.sc) else begin errors++; $error("FAIL %s stall_cnt: got %0d required %0d", e.tag, stall_cnt, e.sc); end
        checks++;
        assert (flush_cnt === e.fc) else begin errors++; $error("FAIL %s flush_cnt: got %0d required %0d", e.tag, flush_cnt, e.fc); end
        checks++;
        assert (mem_timeout_err === e.err) else begin errors++; $error("FAIL %s err: got %b required %b", e.tag, mem_timeout_err, e.err); end
    endtask

    task automatic step(input string tag, input logic l, input logic b, input logic r, input logic a,
                        input logic [7:0] c, input logic [31:0] sc, input logic [31:0] fc, input logic err);
        lh = l; bt = b; req = r; ack = a;
        push(tag, c, sc, fc, err);
        #2;
        check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push("reset", 8'hFE, 0, 0, 1'b0);
        #1;
        check();
        rst_n = 1'b1;
        step("purge1", 0, 0, 0, 0, 8'hFE, 0, 0, 1'b0);
        step("purge2", 0, 0, 0, 0, 8'hFE, 0, 0, 1'b0);
        step("run_idle", 0, 0, 0, 0, 8'h00, 0, 0, 1'b0);
        step("load_use", 1, 0, 0, 0, 8'hC4, 0, 0, 1'b0);
        step("after_lu", 0, 0, 0, 0, 8'h00, 1, 0, 1'b0);
        tgt = 32'h0000_0100;
        step("br_vs_lu", 1, 1, 0, 0, 8'h0D, 1, 0, 1'b0);
        step("after_br", 0, 0, 0, 0, 8'h00, 1, 1, 1'b0);
        step("mem_req", 0, 0, 1, 0, 8'hF2, 1, 1, 1'b0);
        step("mem_wait1", 0, 0, 1, 0, 8'hF2, 2, 1, 1'b0);
        tgt = 32'h0000_0200;
        step("mem_wait_br", 0, 1, 1, 0, 8'hF2, 3, 1, 1'b0);
        step("mem_ack", 0, 1, 1, 1, 8'h00, 4, 1, 1'b0);
        step("late_redir", 0, 1, 0, 0, 8'h0D, 4, 1, 1'b0);
        step("after_redir", 0, 0, 0, 0, 8'h00, 4, 2, 1'b0);
        step("req_ack_same", 0, 0, 1, 1, 8'h00, 4, 2, 1'b0);
        step("no_wait", 0, 0, 0, 0, 8'h00, 4, 2, 1'b0);
        step("to_enter", 0, 0, 1, 0, 8'hF2, 4, 2, 1'b0);
        for (int k = 1; k < 10; k++) step("to_wait", 0, 0, 1, 0, 8'hF2, 32'(4 + k), 2, k >= 5);
        rst_n = 1'b0;
        push("midwait_rst", 8'hFE, 0, 0, 1'b0);
        #2;
        check();
        req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("re_purge1", 0, 0, 0, 0, 8'hFE, 0, 0, 1'b0);
        step("re_purge2", 0, 0, 0, 0, 8'hFE, 0, 0, 1'b0);
        step("re_run", 0, 0, 0, 0, 8'h00, 0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 5-stage RISC-V core (IF, ID, EX, MEM, WB). It consumes the load-use stall request from the operand-forwarding logic in ID, the taken-branch/jump result from EX and the data-memory handshake from MEM. From these it drives per-stage hold and bubble controls plus the PC redirect. It also sequences a post-reset pipeline purge and keeps stall/flush performance counters.

## Interface
Parameters:
- RST_HOLD_CYCLES, 2, cycles after reset release during which the whole pipeline is held and purged (≥1)
- MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_err is raised
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- load_hazard_stall  in  1  ID operand depends on a load currently in EX
- branch_taken_ex  in  1  branch/jump in EX resolved taken
- branch_target_ex  in  XLEN  redirect address
- dmem_req_mem  in  1  MEM-stage instruction is accessing data memory this cycle
- dmem_ack  in  1  data memory completes the access this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC or the named stage's input register
- flush_id, flush_ex, flush_wb  out  1 each  load a bubble into the IF/ID, ID/EX and MEM/WB registers
- pc_redirect_en  out  1  PC loads pc_redirect_addr at the next edge
- pc_redirect_addr  out  XLEN  equals branch_target_ex
- stall_cnt, flush_cnt  out  CNT_W each  performance counters
- mem_timeout_err  out  1  sticky error flag

## Operation
The FSM has three states: PURGE, RUN and MEM_WAIT.
- **PURGE.** Entered on reset. All stall_* outputs are 1, flush_id/ex/wb are 1 and pc_redirect_en is 0. A down-counter runs for RST_HOLD_CYCLES cycles, then the FSM moves to RUN.
- **RUN.** Conditions are evaluated in the priority order below.
  1. **Memory wait.** dmem_req_mem=1 and dmem_ack=0: stall_if/id/ex/mem=1, flush_wb=1 and redirect is suppressed. Next state is MEM_WAIT.
  2. **Taken branch.** branch_taken_ex=1: pc_redirect_en=1 and flush_id=1. flush_ex=1 squashes the ID instruction, and this overrides a simultaneous load_hazard_stall, so no stalls are asserted.
  3. **Load-use.** load_hazard_stall=1: stall_if=1, stall_id=1, flush_ex=1 (one bubble). EX, MEM and WB advance.
  4. **Otherwise:** all controls are 0.
- **MEM_WAIT.** The same outputs as case 1 are held.
  - dmem_ack=1: all controls are released in that cycle and the MEM/WB register captures the result. Next state is RUN.
  - A taken branch sitting in EX is frozen while waiting. It redirects on the first RUN cycle after the ack.
- **Timeout.** A wait counter is cleared on MEM_WAIT entry and increments each cycle in MEM_WAIT, saturating. When it reaches MEM_TIMEOUT, mem_timeout_err is set. The flag is cleared only by reset, and the FSM keeps waiting.
- **Counters.**
  - stall_cnt increments on every cycle with stall_if=1 in RUN or MEM_WAIT.
  - flush_cnt increments on every cycle with pc_redirect_en=1.
  - Both wrap modulo 2^CNT_W and are not counted in PURGE.

## Timing
- Reset values: state=PURGE, counters 0, mem_timeout_err 0, pc_redirect_en 0.
  - Stall/flush outputs read 1 during reset, so the pipeline is held.
- All stall/flush/redirect outputs are combinational from the state and the current inputs, with zero-cycle latency, and are sampled by the pipeline at the next rising edge.
- Counters and mem_timeout_err are registered: visible one cycle after the event.
- A load-use stall lasts exactly one cycle per occurrence. The bubble moves the load to MEM, where forwarding resolves the dependency.
- dmem_req_mem and dmem_ack both 1 in the same cycle: zero wait cycles and no MEM_WAIT entry.
- rst_n asserted mid-MEM_WAIT: immediate return to PURGE with counters cleared. An outstanding memory access is abandoned.
- pc_redirect_addr always equals branch_target_ex. It is meaningful only when pc_redirect_en=1.

## Structure
- Shared package/config entries:
  - FSM state encodings PURGE=2'd0, RUN=2'd1, MEM_WAIT=2'd2
  - XLEN
  - the existing TRUE/FALSE constants
- The module is flat with no sub-module. The optional saturating wait counter may be factored out as sat_counter.

## Test plan
- **Reset purge.** Release rst_n with RST_HOLD_CYCLES=2 → all stalls and flushes 1 for exactly 2 cycles, then 0; stall_cnt=0.
- **Load-use.** Pulse load_hazard_stall for 1 cycle in RUN → stall_if=stall_id=flush_ex=1 for that cycle only; stall_cnt=1 next cycle.
- **Branch beats load-use.** branch_taken_ex=1, branch_target_ex=0x0000_0100 and load_hazard_stall=1 together → pc_redirect_en=1, addr=0x100, flush_id=flush_ex=1, stalls 0; flush_cnt=1.
- **Memory wait.** dmem_req_mem=1 with ack 3 cycles later → stall_if/id/ex/mem and flush_wb high for 3 cycles, released on the ack cycle.
- **Branch during wait.** Branch taken in EX during the same wait → redirect only on the cycle after the ack.
- **Timeout and mid-wait reset.**
  - MEM_TIMEOUT=4 with no ack for 10 cycles → mem_timeout_err rises after the 4th wait cycle and stays high.
  - Assert rst_n low mid-wait → err=0, state PURGE.
